// File: rtl/mul_shift_add_32_bit.sv
// Iterative 32x32 unsigned shift-add multiplier with a 64-bit product.
// One multiplier bit is retired per clock through a 32-bit ripple-carry adder.
// The adder's carry-out feeds the top of the shifting partial product.
// A start/in_ready handshake accepts operands.
// A result_valid/result_ready handshake returns the result.

// 32-bit ripple-carry adder.
// This is the ALU adder datapath that the multiplier borrows every cycle.
module add_rca_32_bit (
    input  logic [31:0] X,
    input  logic [31:0] Y,
    input  logic        ci,
    output logic [31:0] sum,
    output logic        co
);

    logic [32:0] carry;

    // Ripple the carry from bit 0 upward, one full adder per bit
    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = ci;
        for (int i = 0; i < 32; i++) begin
            sum[i]       = X[i] ^ Y[i] ^ carry[i];
            carry[i + 1] = (X[i] & Y[i]) | (X[i] & carry[i]) | (Y[i] & carry[i]);
        end
        co = carry[32];
    end

endmodule

// Multi-cycle multiplier wrapped around a single add_rca_32_bit instance
module mul_shift_add_32_bit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rstb,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 in_ready,
    output logic                 busy,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 hi_nonzero
);

    // The adder instance is hard-wired to 32 bits, so no other width can work
    if (WIDTH != 32) begin : g_width_check
        $error("mul_shift_add_32_bit: WIDTH must be 32");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic [2*WIDTH-1:0]  p_reg;
    logic [WIDTH-1:0]    mcand;
    logic [4:0]          count;

    logic [WIDTH-1:0]    add_x;
    logic [WIDTH-1:0]    add_y;
    logic [WIDTH-1:0]    add_sum;
    logic                add_co;
    logic [2*WIDTH-1:0]  next_p;

    // Adder operands come from the upper half of the partial product.
    // The current multiplier LSB gates whether the multiplicand is added.
    always_comb begin
        add_x  = p_reg[2*WIDTH-1:WIDTH];
        add_y  = p_reg[0] ? mcand : '0;
        next_p = {add_co, add_sum, p_reg[WIDTH-1:1]};
    end

    add_rca_32_bit u_adder (
        .X   (add_x),
        .Y   (add_y),
        .ci  (1'b0),
        .sum (add_sum),
        .co  (add_co)
    );

    // Partial product is exposed directly. During BUSY it is only meaningful
    // when qualified by result_valid.
    assign product = p_reg;

    // Control FSM and datapath registers.
    // Handshake outputs are registered alongside the state so they always
    // decode the current state.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state        <= IDLE;
            p_reg        <= '0;
            mcand        <= '0;
            count        <= '0;
            hi_nonzero   <= 1'b0;
            in_ready     <= 1'b1;
            busy         <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand        <= a;
                        p_reg        <= {{WIDTH{1'b0}}, b};
                        count        <= '0;
                        state        <= BUSY;
                        in_ready     <= 1'b0;
                        busy         <= 1'b1;
                        result_valid <= 1'b0;
                    end
                end
                BUSY: begin
                    p_reg <= next_p;
                    count <= count + 5'd1;
                    if (count == 5'd31) begin
                        hi_nonzero   <= |next_p[2*WIDTH-1:WIDTH];
                        state        <= DONE;
                        in_ready     <= 1'b0;
                        busy         <= 1'b0;
                        result_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        state        <= IDLE;
                        in_ready     <= 1'b1;
                        busy         <= 1'b0;
                        result_valid <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    in_ready     <= 1'b1;
                    busy         <= 1'b0;
                    result_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_shift_add_32_bit.sv
// Self-checking bench for mul_shift_add_32_bit.
// Expected products are pushed to a queue when operands are driven.
// They are popped and compared when the DUT raises result_valid.
module tb_mul_shift_add_32_bit;

    logic        clk = 1'b0;
    logic        rstb;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        in_ready;
    logic        busy;
    logic        result_valid;
    logic        result_ready;
    logic [63:0] product;
    logic        hi_nonzero;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    mul_shift_add_32_bit #(.WIDTH(32)) dut (
        .clk          (clk),
        .rstb         (rstb),
        .start        (start),
        .a            (a),
        .b            (b),
        .in_ready     (in_ready),
        .busy         (busy),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .product      (product),
        .hi_nonzero   (hi_nonzero)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Single comparison point, counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    // Run one multiply: wait for in_ready, launch, measure latency, score the result,
    // apply backpressure for ready_delay cycles, then release.
    // With hold_start set, start stays high and a/b churn every cycle.
    task automatic applyStimulus(input logic [31:0] op_a, input logic [31:0] op_b,
                                 input int ready_delay, input bit hold_start);
        int n;
        logic [63:0] expected;
        logic [63:0] held;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("in_ready_wait", {63'b0, in_ready}, 64'd1);
        a     = op_a;
        b     = op_b;
        start = 1'b1;
        exp_q.push_back({32'b0, op_a} * {32'b0, op_b});
        @(posedge clk);
        #1;
        checkOutput("in_ready_drop", {63'b0, in_ready}, 64'd0);
        checkOutput("busy_rise", {63'b0, busy}, 64'd1);
        if (!hold_start) start = 1'b0;
        n = 0;
        while (!result_valid && n < 40) begin
            if (hold_start) begin
                a = $urandom;
                b = $urandom;
            end
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("latency", 64'(n), 64'd32);
        if (exp_q.size() == 0) begin
            checkOutput("queue_empty", 64'd0, 64'd1);
            expected = '0;
        end else begin
            expected = exp_q.pop_front();
        end
        checkOutput("product", product, expected);
        checkOutput("hi_nonzero", {63'b0, hi_nonzero}, {63'b0, (expected[63:32] != 32'd0)});
        held = product;
        result_ready = 1'b0;
        for (int i = 0; i < ready_delay; i++) begin
            if (hold_start) begin
                a = $urandom;
                b = $urandom;
            end
            @(posedge clk);
            #1;
            checkOutput("hold_product", product, held);
            checkOutput("hold_valid", {63'b0, result_valid}, 64'd1);
        end
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
        checkOutput("release_in_ready", {63'b0, in_ready}, 64'd1);
        checkOutput("release_busy", {63'b0, busy}, 64'd0);
        checkOutput("release_valid", {63'b0, result_valid}, 64'd0);
    endtask

    // Global time limit so the run can never hang
    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence
    initial begin
        rstb         = 1'b0;
        start        = 1'b0;
        a            = '0;
        b            = '0;
        result_ready = 1'b0;
        #12;
        checkOutput("reset_product", product, 64'd0);
        checkOutput("reset_hi", {63'b0, hi_nonzero}, 64'd0);
        checkOutput("reset_in_ready", {63'b0, in_ready}, 64'd1);
        checkOutput("reset_busy", {63'b0, busy}, 64'd0);
        checkOutput("reset_valid", {63'b0, result_valid}, 64'd0);
        @(negedge clk);
        rstb = 1'b1;

        $display("[TB] directed operands");
        applyStimulus(32'd3, 32'd5, 0, 1'b0);
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
        applyStimulus(32'd0, 32'hDEAD_BEEF, 0, 1'b0);
        applyStimulus(32'h8000_0000, 32'd2, 0, 1'b0);

        $display("[TB] start held high, backpressure 10 cycles");
        applyStimulus(32'h1234_5678, 32'h9ABC_DEF0, 10, 1'b1);
        applyStimulus(32'h0000_FFFF, 32'hFFFF_0000, 0, 1'b0);

        $display("[TB] reset mid-operation");
        @(negedge clk);
        a     = 32'hCAFE_F00D;
        b     = 32'h0BAD_BEEF;
        start = 1'b1;
        exp_q.push_back({32'b0, a} * {32'b0, b});
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        checkOutput("mid_busy", {63'b0, busy}, 64'd1);
        rstb = 1'b0;
        #1;
        checkOutput("mid_reset_product", product, 64'd0);
        checkOutput("mid_reset_valid", {63'b0, result_valid}, 64'd0);
        checkOutput("mid_reset_in_ready", {63'b0, in_ready}, 64'd1);
        checkOutput("mid_reset_busy", {63'b0, busy}, 64'd0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rstb = 1'b1;
        applyStimulus(32'd7, 32'd6, 0, 1'b0);

        $display("[TB] randomised back-to-back");
        for (int k = 0; k < 1000; k++) begin
            applyStimulus($urandom, $urandom, $urandom_range(0, 3), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
